// File: rtl/vga_capture.sv
// VGA sink: recovers pixel coordinates from the sync timing and captures one
// armed frame as an x/y tagged pixel stream with a running count and checksum.
module vga_capture #(
  parameter int H_ACTIVE        = 640,
  parameter int H_BACK_PORCH    = 48,
  parameter int V_ACTIVE        = 480,
  parameter int V_BACK_PORCH    = 33,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        arm,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [23:0] rgb_in,
  output logic        pixel_valid,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic [23:0] pixel_data,
  output logic        busy,
  output logic        frame_done,
  output logic        timing_error,
  output logic [19:0] pixel_count,
  output logic [31:0] checksum
);

  typedef enum logic [1:0] {IDLE, WAIT_VSYNC, CAPTURE, DONE} state_t;

  localparam logic [10:0] H_LO   = 11'(H_BACK_PORCH);
  localparam logic [10:0] H_HI   = 11'(H_BACK_PORCH + H_ACTIVE);
  localparam logic [10:0] H_FULL = 11'(H_BACK_PORCH + H_ACTIVE - 1);
  localparam logic [9:0]  V_LO   = 10'(V_BACK_PORCH);
  localparam logic [9:0]  V_HI   = 10'(V_BACK_PORCH + V_ACTIVE);
  localparam logic [9:0]  X_LAST = 10'(H_ACTIVE - 1);
  localparam logic [9:0]  Y_LAST = 10'(V_ACTIVE - 1);

  state_t state, state_nx;

  logic        hs_q, vs_q, hs_p, vs_p;
  logic [23:0] rgb_q;
  logic [10:0] h_reg, h_cnt;
  logic [9:0]  line_reg, line_cnt;
  logic        hs_rise, hs_start, vs_rise, vs_fall;
  logic        active, last, err_v, err_h;
  logic [9:0]  x_cur, y_cur;

  always_ff @(posedge clk) begin
    if (!reset) begin
      hs_q     <= 1'b0;
      vs_q     <= 1'b0;
      hs_p     <= 1'b0;
      vs_p     <= 1'b0;
      rgb_q    <= '0;
      h_reg    <= '0;
      line_reg <= '0;
    end else begin
      hs_q     <= SYNC_ACTIVE_LOW ? ~hsync : hsync;
      vs_q     <= SYNC_ACTIVE_LOW ? ~vsync : vsync;
      hs_p     <= hs_q;
      vs_p     <= vs_q;
      rgb_q    <= rgb_in;
      h_reg    <= h_cnt;
      line_reg <= line_cnt;
    end
  end

  assign hs_rise  = hs_q & ~hs_p;
  assign hs_start = ~hs_q & hs_p;
  assign vs_rise  = vs_q & ~vs_p;
  assign vs_fall  = ~vs_q & vs_p;

  always_comb begin
    h_cnt = h_reg;
    if (hs_start)
      h_cnt = '0;
    else if (!hs_q && h_reg != '1)
      h_cnt = h_reg + 11'd1;
  end

  always_comb begin
    line_cnt = line_reg;
    if (vs_fall)
      line_cnt = '0;
    else if (hs_rise && !vs_q && line_reg != '1)
      line_cnt = line_reg + 10'd1;
  end

  assign active = !vs_q && !hs_q
                  && line_cnt >= V_LO && line_cnt < V_HI
                  && h_cnt >= H_LO && h_cnt < H_HI;
  assign x_cur  = 10'(h_cnt - H_LO);
  assign y_cur  = line_cnt - V_LO;
  assign last   = active && x_cur == X_LAST && y_cur == Y_LAST;

  // A line is short when hsync returns before its last pixel was seen.
  assign err_v  = vs_rise;
  assign err_h  = hs_rise && !vs_q && !vs_p
                  && line_reg >= V_LO && line_reg < V_HI
                  && h_reg >= H_LO && h_reg < H_FULL;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:       if (arm) state_nx = WAIT_VSYNC;
      WAIT_VSYNC: if (vs_rise) state_nx = CAPTURE;
      CAPTURE: begin
        if (err_v || err_h) state_nx = IDLE;
        else if (last)      state_nx = DONE;
      end
      DONE:       state_nx = IDLE;
      default:    state_nx = IDLE;
    endcase
  end

  assign busy = (state == WAIT_VSYNC) || (state == CAPTURE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      pixel_valid  <= 1'b0;
      pixel_x      <= '0;
      pixel_y      <= '0;
      pixel_data   <= '0;
      frame_done   <= 1'b0;
      timing_error <= 1'b0;
      pixel_count  <= '0;
      checksum     <= '0;
    end else begin
      frame_done  <= (state == DONE);
      pixel_valid <= (state == CAPTURE) && active;
      if (state == IDLE && arm) begin
        timing_error <= 1'b0;
        pixel_count  <= '0;
        checksum     <= '0;
      end
      if (state == CAPTURE && (err_v || err_h))
        timing_error <= 1'b1;
      if (state == CAPTURE && active) begin
        pixel_x     <= x_cur;
        pixel_y     <= y_cur;
        pixel_data  <= rgb_q;
        pixel_count <= pixel_count + 20'd1;
        checksum    <= checksum + {8'd0, rgb_q};
      end
    end
  end

endmodule

// File: tb/tb_vga_capture.sv
// Bench for vga_capture: a small raster source drives frames and the captured
// stream, count, checksum and status are compared with the frames it drew.
module tb_vga_capture;

  localparam int H  = 4;
  localparam int HB = 2;
  localparam int V  = 3;
  localparam int VB = 1;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [23:0] d;
  } pix_t;

  logic        clk = 1'b0;
  logic        reset, arm, hsync, vsync;
  logic [23:0] rgb_in;
  logic        pixel_valid, busy, frame_done, timing_error;
  logic [9:0]  pixel_x, pixel_y;
  logic [23:0] pixel_data;
  logic [19:0] pixel_count;
  logic [31:0] checksum;

  int   tests = 0;
  int   fails = 0;
  int   mode = 0;
  bit   cap = 1'b0;
  int   arm_row = -1;
  int   rst_row = -1;
  bit   watch_start = 1'b0;
  bit   watch_end = 1'b0;
  int   busy_low = 0;
  int   fd_cnt = 0;
  int   fd_base = 0;
  int   obs_base = 0;
  pix_t obs[$];
  pix_t exp_q[$];

  vga_capture #(
    .H_ACTIVE(H), .H_BACK_PORCH(HB),
    .V_ACTIVE(V), .V_BACK_PORCH(VB),
    .SYNC_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .arm(arm),
    .hsync(hsync), .vsync(vsync), .rgb_in(rgb_in),
    .pixel_valid(pixel_valid), .pixel_x(pixel_x),
    .pixel_y(pixel_y), .pixel_data(pixel_data),
    .busy(busy), .frame_done(frame_done),
    .timing_error(timing_error),
    .pixel_count(pixel_count), .checksum(checksum)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (pixel_valid) obs.push_back({pixel_x, pixel_y, pixel_data});
    if (frame_done) fd_cnt++;
    if (!watch_start) watch_end = 1'b0;
    else if (!watch_end) begin
      if (pixel_valid && pixel_x == 10'(H-1) && pixel_y == 10'(V-1))
        watch_end = 1'b1;
      else if (!busy)
        busy_low++;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [23:0] pix_val(input int x, input int y);
    if (mode == 0) return {12'(y), 12'(x)};
    if (mode == 1) return 24'hFFFFFF;
    return 24'($urandom);
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 64'(pixel_valid), 64'd0);
    chk({tag, "_xyd"}, 64'({pixel_x, pixel_y, pixel_data}), 64'd0);
    chk({tag, "_stat"}, 64'({busy, frame_done, timing_error}), 64'd0);
    chk({tag, "_cnt"}, 64'(pixel_count), 64'd0);
    chk({tag, "_sum"}, 64'(checksum), 64'd0);
  endtask

  // One line: hsync pulse, then porch/pixels; y < 0 means no active pixels.
  task automatic do_line(input bit vs_act, input int y, input int cut,
                         input int extra);
    int n;
    for (int j = 0; j < 2; j++) begin
      vsync  = ~vs_act;
      hsync  = 1'b0;
      rgb_in = 24'($urandom);
      if (j == 0 && y >= 0 && y == arm_row) begin
        arm = 1'b1;
        tick;
        arm = 1'b0;
        watch_start = 1'b1;
      end else tick;
    end
    n = (cut >= 0) ? HB + cut + 1 : HB + H + 2 + extra;
    for (int j = 0; j < n; j++) begin
      hsync = 1'b1;
      if (y >= 0 && j >= HB && j < HB + H) begin
        rgb_in = pix_val(j - HB, y);
        if (y == rst_row && j == HB) cap = 1'b0;
        if (cap) exp_q.push_back({10'(j - HB), 10'(y), rgb_in});
        if (y == rst_row && j == HB + 1) begin
          reset = 1'b0;
          tick;
          reset = 1'b1;
          chk_zero("midrst");
        end else tick;
      end else begin
        rgb_in = 24'($urandom);
        tick;
      end
    end
  endtask

  task automatic frame(input int nrows, input int cut);
    do_line(1'b1, -1, -1, 0);
    do_line(1'b1, -1, -1, 0);
    do_line(1'b0, -1, -1, int'($urandom_range(0, 3)));
    for (int r = 0; r < nrows; r++) begin
      do_line(1'b0, r, (r == 0) ? cut : -1, int'($urandom_range(0, 3)));
      if (r == 0 && cut >= 0) cap = 1'b0;
    end
    if (nrows < V) do_line(1'b1, -1, -1, 0);
    else begin
      do_line(1'b0, -1, -1, 0);
      if ($urandom_range(0, 1) == 1) do_line(1'b0, -1, -1, 1);
    end
    cap = 1'b0;
  endtask

  task automatic idle(input int n);
    hsync = 1'b1;
    vsync = 1'b1;
    rgb_in = '0;
    for (int i = 0; i < n; i++) tick;
  endtask

  task automatic arm_pulse;
    arm = 1'b1;
    tick;
    arm = 1'b0;
  endtask

  task automatic chk_frame(input string tag, input bit err, input int fd,
                           input bit rst);
    logic [31:0] s;
    int n, got_n;
    s = '0;
    n = exp_q.size();
    got_n = obs.size() - obs_base;
    foreach (exp_q[i]) s = s + {8'd0, exp_q[i].d};
    chk({tag, "_npix"}, 64'(got_n), 64'(n));
    for (int i = 0; i < n && i < got_n; i++)
      chk({tag, "_pix"}, 64'(obs[obs_base + i]), 64'(exp_q[i]));
    chk({tag, "_cnt"}, 64'(pixel_count), rst ? 64'd0 : 64'(n));
    chk({tag, "_sum"}, 64'(checksum), rst ? 64'd0 : 64'(s));
    chk({tag, "_terr"}, 64'(timing_error), 64'(err));
    chk({tag, "_fdone"}, 64'(fd_cnt - fd_base), 64'(fd));
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    exp_q.delete();
    obs_base = obs.size();
    fd_base = fd_cnt;
  endtask

  initial begin
    reset = 1'b0;
    arm = 1'b0;
    hsync = 1'b1;
    vsync = 1'b1;
    rgb_in = '0;
    idle(3);
    chk_zero("reset");
    reset = 1'b1;
    idle(5);

    mode = 0;
    arm_pulse;
    cap = 1'b1;
    frame(V, -1);
    idle(4);
    chk_frame("yx", 1'b0, 1, 1'b0);

    mode = 1;
    arm_pulse;
    cap = 1'b1;
    frame(V, -1);
    idle(4);
    chk("ones_sum", 64'(checksum), 64'd201326580);
    chk_frame("ones", 1'b0, 1, 1'b0);

    mode = 2;
    for (int k = 0; k < 3; k++) begin
      arm_pulse;
      cap = 1'b1;
      frame(V, -1);
      idle(int'($urandom_range(1, 6)));
      chk_frame("rand", 1'b0, 1, 1'b0);
    end

    arm_row = 1;
    cap = 1'b0;
    frame(V, -1);
    arm_row = -1;
    cap = 1'b1;
    frame(V, -1);
    idle(4);
    watch_start = 1'b0;
    chk("mid_busy_low", 64'(busy_low), 64'd0);
    chk_frame("midarm", 1'b0, 1, 1'b0);

    arm_pulse;
    cap = 1'b1;
    frame(2, -1);
    idle(4);
    chk("early_cnt", 64'(pixel_count), 64'd8);
    chk_frame("early_vs", 1'b1, 0, 1'b0);

    arm_pulse;
    cap = 1'b1;
    frame(V, 1);
    idle(4);
    chk_frame("short", 1'b1, 0, 1'b0);
    arm_pulse;
    chk("rearm_terr", 64'(timing_error), 64'd0);
    chk("rearm_busy", 64'(busy), 64'd1);
    cap = 1'b1;
    frame(V, -1);
    idle(4);
    chk_frame("after_short", 1'b0, 1, 1'b0);

    arm_pulse;
    cap = 1'b1;
    rst_row = 1;
    frame(V, -1);
    rst_row = -1;
    idle(4);
    chk_frame("rst", 1'b0, 0, 1'b1);
    arm_pulse;
    cap = 1'b1;
    frame(V, -1);
    idle(4);
    chk_frame("after_rst", 1'b0, 1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vga_capture.md
Name: vga_capture

Overview:
Synthesizable VGA sink that sits on the hsync/vsync/rgb_out pins driven by mide_cpu, on the same GPU pixel clock. When armed, it recovers pixel coordinates from the sync timing and captures exactly one active frame as a pixel stream with x/y tags. It also keeps a running pixel count and checksum, so benches and on-board self-test can verify rendered images without text-file dumps.

Parameters:
H_ACTIVE, 640, active pixels per line
H_BACK_PORCH, 48, clocks from first hsync-inactive sample to pixel x=0
V_ACTIVE, 480, active lines per frame
V_BACK_PORCH, 33, complete lines after vsync deassertion before line y=0
SYNC_ACTIVE_LOW, 1, 1 = hsync/vsync asserted when 0

Ports:
clk  in  1  pixel clock (gpu_clk domain)
reset  in  1  synchronous, active-low reset
arm  in  1  request capture of next full frame; sampled in IDLE only
hsync  in  1  horizontal sync from display source
vsync  in  1  vertical sync from display source
rgb_in  in  24  pixel {r[23:16], g[15:8], b[7:0]}
pixel_valid  out  1  pixel_x/pixel_y/pixel_data hold a captured pixel
pixel_x  out  10  column, 0..H_ACTIVE-1
pixel_y  out  10  row, 0..V_ACTIVE-1
pixel_data  out  24  captured rgb
busy  out  1  state is WAIT_VSYNC or CAPTURE
frame_done  out  1  one-cycle pulse after last pixel of a good frame
timing_error  out  1  sticky; cleared on accepted arm
pixel_count  out  20  valid pixels emitted this capture
checksum  out  32  wrapping sum of zero-extended pixel_data over capture

Behaviour:
- Reset (reset==0 at posedge): every output 0, all counters 0, state IDLE, input registers 0 (inactive). Reset mid-frame aborts capture without frame_done.
- Stage 1 registers hsync, vsync, rgb_in; syncs normalised to active-high (hs, vs). Edges from stage 1 vs its previous value. Outputs registered from stage 1: pin-to-output latency 2 clocks.
- h_cnt (11b): 0 on the first hs-inactive cycle, +1 per inactive cycle, saturates at 2047, holds while hs active.
- line_cnt (10b): 0 on vs deassertion edge; +1 on each hs assertion edge while vs inactive; saturates at 1023.
- Active pixel: vs inactive, hs inactive, V_BACK_PORCH <= line_cnt < V_BACK_PORCH+V_ACTIVE, H_BACK_PORCH <= h_cnt < H_BACK_PORCH+H_ACTIVE. pixel_x = h_cnt-H_BACK_PORCH, pixel_y = line_cnt-V_BACK_PORCH.
- FSM:
  IDLE: arm==1 -> WAIT_VSYNC; clear timing_error, pixel_count, checksum.
  WAIT_VSYNC: vs assertion edge -> CAPTURE. No pixels emitted, so a frame already in progress is never partially captured.
  CAPTURE: pixel_valid=1 on active pixels; pixel_count+1 and checksum+=pixel_data on each. After the pixel at (H_ACTIVE-1, V_ACTIVE-1) -> DONE.
  DONE: frame_done=1 for exactly one cycle -> IDLE.
- pixel_valid is 0 outside CAPTURE; pixel_x/y/data hold their last value when pixel_valid=0.
- Errors in CAPTURE set timing_error, go to IDLE, no frame_done, and keep pixel_count/checksum for debug:
  (a) vs assertion edge before the last active line completes;
  (b) hs assertion edge inside the active window (short line).
- Long lines or lines with extra porch are tolerated, not errors.
- arm while busy is ignored. arm in the same cycle as DONE is ignored (DONE is not IDLE).
- Counter arithmetic is unsigned. checksum wraps modulo 2^32.

Test Plan:
- Params H_ACTIVE=4, H_BACK_PORCH=2, V_ACTIVE=3, V_BACK_PORCH=1; source gives rgb = {y,x} pattern; arm -> 12 pixels in raster order (0,0)..(3,2), pixel_count=12, one frame_done pulse, timing_error=0.
- Same params, all pixels 24'hFFFFFF -> checksum = 12*16777215 = 201326580.
- arm mid-frame (line 1 active) -> no output until next vsync; capture of the following frame exact; busy high throughout.
- vsync asserted after 2 of 3 active lines -> timing_error=1, frame_done never pulses, state IDLE, pixel_count=8.
- hsync asserted after pixel x=1 on line 0 -> timing_error=1; next arm clears it; clean frame then completes.
- reset low for one clock during CAPTURE -> all outputs 0 next cycle; no frame_done; re-arm captures a full 12-pixel frame.
